// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone command master: queued command record,
// FSM state encoding and the default error-data pattern.
package wb_cmd_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command queue: power-of-two depth, wrapping pointers and a
// separate occupancy count so full and empty are never ambiguous.
module wb_cmd_fifo
  import wb_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  wb_cmd_t                  push_data,
  input  logic                     pop,
  output wb_cmd_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  wb_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master fed by a command queue; returns
// one response per command carrying read data or a timeout error.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t                       state;
  logic [TW-1:0]                timer;
  wb_cmd_t                      cmd_in;
  wb_cmd_t                      head;
  logic                         full;
  logic                         empty;
  logic [$clog2(FIFO_DEPTH):0]  count;
  logic                         pop;
  logic                         terminal;

  assign cmd_in    = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
  assign cmd_ready = !full;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (count != '0) || (state != IDLE);
  assign terminal  = (timer == TW'(TIMEOUT_CYCLES - 1));

  wb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (wb_clk_i),
    .reset     (wb_rst_i),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Ack is checked before the terminal count so a last-cycle ack still succeeds.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      timer     <= '0;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbs_we_o  <= 1'b0;
      wbs_sel_o <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      case (state)
        IDLE: begin
          if (!empty) begin
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            wbs_we_o  <= head.we;
            wbs_sel_o <= head.sel;
            wbs_adr_o <= head.adr;
            wbs_dat_o <= head.dat;
            timer     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (wbs_ack_i || terminal) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= '0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= !wbs_ack_i;
            if (!wbs_ack_i) begin
              rsp_dat <= ERR_DATA;
            end else if (!wbs_we_o) begin
              rsp_dat <= wbs_dat_i;
            end
            state <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
